// File: rtl/tbs_rx_multi.sv
// Multi-channel TBS receiver: per-channel sync + glitch filter, edge-to-UART-low stretcher,
// sticky early-retrigger flag and line-idle detection, sharing one programmable bit period.
module tbs_rx_multi #(
    parameter int NUM_CH         = 4,
    parameter int DEFAULT_PERIOD = 434,
    parameter int GLITCH_CYC     = 3,
    parameter int IDLE_BITS      = 10
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic [NUM_CH-1:0] TBS_in,
    input  logic [15:0]       cfg_period,
    input  logic              cfg_load,
    input  logic [NUM_CH-1:0] err_clr,
    output logic [NUM_CH-1:0] rs232_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] err_early,
    output logic [NUM_CH-1:0] idle
);

    localparam int IDLE_W = 16 + $clog2(IDLE_BITS + 1);
    localparam int FC_W   = (GLITCH_CYC < 2) ? 1 : $clog2(GLITCH_CYC);

    logic [15:0]       r_period;
    logic [15:0]       w_half;
    logic [IDLE_W-1:0] w_idle_thr;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_period <= 16'(DEFAULT_PERIOD);
        end else if (cfg_load && (cfg_period >= 16'd2)) begin
            r_period <= cfg_period;
        end
    end

    assign w_half     = r_period >> 1;
    assign w_idle_thr = IDLE_W'(IDLE_BITS) * IDLE_W'(r_period);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [1:0]        r_sync;
        logic              w_level;
        logic              w_level_next;
        logic              w_fall;
        logic              w_end;
        logic [15:0]       r_cnt;
        logic              r_busy;
        logic              r_out;
        logic              r_err;
        logic [IDLE_W-1:0] r_idle_cnt;

        always_ff @(posedge clk_50M) begin
            if (rst) begin
                r_sync <= 2'b11;
            end else begin
                r_sync <= {r_sync[0], TBS_in[i]};
            end
        end

        // The edge is detected from the level about to be registered, so the stretch starts
        // on the same clock edge the filtered level falls.
        if (GLITCH_CYC == 0) begin : g_bypass
            assign w_level      = r_sync[1];
            assign w_level_next = r_sync[0];
        end else begin : g_filt
            logic            r_filt;
            logic [FC_W-1:0] r_fcnt;
            logic            w_flip;

            assign w_flip = (r_sync[1] != r_filt) && (r_fcnt == FC_W'(GLITCH_CYC - 1));

            always_ff @(posedge clk_50M) begin
                if (rst) begin
                    r_filt <= 1'b1;
                    r_fcnt <= '0;
                end else if (r_sync[1] == r_filt) begin
                    r_fcnt <= '0;
                end else if (w_flip) begin
                    r_filt <= ~r_filt;
                    r_fcnt <= '0;
                end else begin
                    r_fcnt <= r_fcnt + 1'b1;
                end
            end

            assign w_level      = r_filt;
            assign w_level_next = r_filt ^ w_flip;
        end

        assign w_fall = w_level & ~w_level_next;
        assign w_end  = r_cnt >= (r_period - 16'd1);

        // A retrigger wins over a stretch ending on the same edge, keeping the line low.
        always_ff @(posedge clk_50M) begin
            if (rst) begin
                r_cnt  <= '0;
                r_busy <= 1'b0;
                r_out  <= 1'b1;
            end else if (w_fall) begin
                r_cnt  <= '0;
                r_busy <= 1'b1;
                r_out  <= 1'b0;
            end else if (r_busy) begin
                if (w_end) begin
                    r_busy <= 1'b0;
                    r_out  <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
        end

        always_ff @(posedge clk_50M) begin
            if (rst) begin
                r_err <= 1'b0;
            end else if (w_fall && r_busy && (r_cnt < w_half)) begin
                r_err <= 1'b1;
            end else if (err_clr[i]) begin
                r_err <= 1'b0;
            end
        end

        always_ff @(posedge clk_50M) begin
            if (rst || w_fall || r_busy || !w_level) begin
                r_idle_cnt <= '0;
            end else if (r_idle_cnt < w_idle_thr) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end else begin
                r_idle_cnt <= w_idle_thr;
            end
        end

        assign rs232_out[i] = r_out;
        assign busy[i]      = r_busy;
        assign err_early[i] = r_err;
        assign idle[i]      = (r_idle_cnt >= w_idle_thr);
    end

endmodule
